alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 64-bit combinational ALU between two requesters, for example the execute stage and a debug/address port. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and registers the winner's operands into the ALU input bus. It captures BusW and Zero one cycle later and holds the response until the owner accepts it. Opcodes outside the ALU's legal set are trapped here and never reach the ALU.

## Interface
Parameters:
- WIDTH, 64, datapath width of the operands and the result.
- NREQ, 2, number of requesters; fixed at 2, and any other value is a synthesis error.

Ports (n = 0, 1 for each per-requester port):
- CLK  in  1  single clock; all state updates on the rising edge.
- Reset_L  in  1  reset, asynchronous and active-low.
- reqn_valid  in  1  requester n presents an operation.
- reqn_ready  out  1  request accepted this cycle.
- reqn_a, reqn_b  in  WIDTH  operands; map to ALU BusA and BusB.
- reqn_ctrl  in  4  ALU control code.
- rspn_valid  out  1  result available for requester n.
- rspn_ready  in  1  requester n takes the result.
- rspn_result  out  WIDTH  registered BusW.
- rspn_zero  out  1  registered Zero.
- rspn_err  out  1  illegal opcode trapped.
- alu_a, alu_b  out  WIDTH  to ALU BusA and BusB; registered.
- alu_ctrl  out  4  to ALUCtrl; registered.
- alu_w  in  WIDTH  from ALU BusW.
- alu_zero  in  1  from ALU Zero.

## Operation
- Legal codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111. Every other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If no reqn_valid is asserted, stay in IDLE.
  - Winner selection: if exactly one requester is valid, it wins. If both are valid, the requester named by the priority pointer `prio` wins.
  - reqn_ready is combinational and equals reqn_valid & (winner == n) & (state == IDLE). At most one ready is high per cycle.
  - On acceptance, latch a, b, ctrl and the owner ID, then go to EXEC.
  - Legal ctrl: alu_a, alu_b and alu_ctrl load from the winner's request.
  - Illegal ctrl: alu_* keep their previous values and the err flag is set.
- **EXEC:**
  - Legal op: capture alu_w into result and alu_zero into zero, with err = 0.
  - Illegal op: result = 0, zero = 1, err = 1.
  - Go to RESP.
- **RESP:**
  - rsp{owner}_valid = 1. The other requester's rsp_valid stays 0.
  - result, zero and err are driven on both requesters' rsp buses but qualified only by valid.
  - Held stable until rsp{owner}_ready. On the cycle where valid & ready, go to IDLE and set `prio` to the requester that was not the owner.
- New requests are not accepted in EXEC or RESP; reqn_ready = 0 in those states. A request held valid while blocked must be accepted no later than the next IDLE cycle in which it wins.
- No WIDTH-related arithmetic happens here; the ALU's wrap-around is passed through unchanged.

## Timing
- Reset values: state IDLE, prio 0, owner 0, alu_a = alu_b = 0, alu_ctrl 0000 (AND), result 0, zero 0, err 0. All rspn_valid and reqn_ready are 0.
- Latency: request accepted in cycle N, ALU driven during N+1, rsp_valid first high in N+2.
- Maximum throughput is one operation per 3 cycles when rsp_ready is held high.
- rsp_ready low stalls the block in RESP indefinitely; the registered outputs must not change while stalled.
- Both requesters valid in IDLE: exactly one grant, and the loser is granted next, giving strict alternation under continuous contention.
- A response handshake in RESP and a new request in the same cycle: the request is not accepted until the following cycle, in IDLE.
- Reset_L asserted in any state: all registers go to their reset values immediately. Any in-flight operation is dropped and no response is produced.
- Outputs are glitch-free and registered; the only combinational outputs are reqn_ready and rspn_valid, which are decoded from state.

## Structure
- Shared package `alu_pkg`:
  - opcode constants AND/OR/ADD/SUB/PassB, shared with the ALU;
  - `is_legal_op` function;
  - FSM state encoding.
- The ALU is instantiated beside this block at the datapath level, not inside it.
- Sub-module `rr_arb2`: two-input round-robin arbiter. Inputs are req[1:0], prio and an enable; outputs are a one-hot grant and the winner index.

## Test plan
- Req0 ADD a=5, b=3 → rsp0_valid in cycle N+2 with result 8, zero 0, err 0; rsp1_valid stays 0.
- Req1 SUB a=7, b=7 with rsp1_ready low for 4 cycles → result 0 and zero 1 held stable for all 4 cycles, then released on ready.
- Both valid every cycle, each issuing PassB of its own ID, rsp_ready tied high → grant order 0, 1, 0, 1; one response every 3 cycles.
- Req0 ctrl 1111 → rsp0 result 0, zero 1, err 1, and alu_ctrl unchanged from the previous legal operation.
- Reset_L dropped during EXEC of req0 AND 0xFF & 0x0F → no rsp0_valid after release, state IDLE, prio 0, and the next request completes normally.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → result 0, zero 1 (wrap-around).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its front-end arbiter: opcode
// encodings, the legal-opcode test and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True only for the five operations the ALU implements.
  function automatic logic is_legal_op(input logic [3:0] ctrl);
    case (ctrl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; when both
// request, the one named by prio_i wins. Grants are suppressed when en_i
// is low, but the winner index is always computed.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  logic win;

  // Pick the winner and form the one-hot grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win   = 1'b0;
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = prio_i;
      default: win = 1'b0;
    endcase
    if (en_i && req_i[win]) gnt_o[win] = 1'b1;
  end

  assign idx_o = win;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// IDLE arbitrates and registers the winner's operands onto the ALU bus,
// EXEC captures the ALU result, RESP holds it until the owner accepts.
// Illegal opcodes never reach the ALU and complete with err set.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero
);

  // The port list is written for exactly two requesters.
  if (NREQ != 2) begin : g_bad_nreq
    $error("alu_arbiter supports NREQ == 2 only");
  end

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, result_q;
  logic [3:0]       alu_ctrl_q;
  logic             zero_q, err_q;

  logic [1:0]       gnt;
  logic             win_idx;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] win_a, win_b;
  logic [3:0]       win_ctrl;

  rr_arb2 u_arb (
    .req_i  ({req1_valid, req0_valid}),
    .prio_i (prio_q),
    .en_i   (state_q == ST_IDLE),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = |gnt;

  assign win_a    = win_idx ? req1_a    : req0_a;
  assign win_b    = win_idx ? req1_b    : req0_b;
  assign win_ctrl = win_idx ? req1_ctrl : req0_ctrl;

  assign rsp_hs = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // Arbitration FSM; all datapath registers update alongside the state.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= OP_AND;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= win_idx;
            err_q   <= !is_legal_op(win_ctrl);
            // Illegal opcodes leave the ALU bus untouched.
            if (is_legal_op(win_ctrl)) begin
              alu_a_q    <= win_a;
              alu_b_q    <= win_b;
              alu_ctrl_q <= win_ctrl;
            end
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (err_q) begin
            result_q <= '0;
            zero_q   <= 1'b1;
          end else begin
            result_q <= alu_w;
            zero_q   <= alu_zero;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            prio_q  <= ~owner_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ctrl = alu_ctrl_q;

  assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU beside it.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  logic             CLK = 1'b0;
  logic             Reset_L;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_ctrl, req1_ctrl;
  logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_w;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  // Reference ALU sitting on the datapath next to the arbiter.
  always_comb begin
    alu_w = '0;
    case (alu_ctrl)
      OP_AND:   alu_w = alu_a & alu_b;
      OP_OR:    alu_w = alu_a | alu_b;
      OP_ADD:   alu_w = alu_a + alu_b;
      OP_SUB:   alu_w = alu_a - alu_b;
      OP_PASSB: alu_w = alu_b;
      default:  alu_w = '0;
    endcase
  end
  assign alu_zero = (alu_w == '0);

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(2)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_w(alu_w), .alu_zero(alu_zero)
  );

  // Advance to 2 ns after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = OP_AND;
    req1_a = '0; req1_b = '0; req1_ctrl = OP_AND;
    #12;
    vectors++; if (alu_a !== '0) begin miscompares++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
    vectors++; if (alu_b !== '0) begin miscompares++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
    vectors++; if (alu_ctrl !== 4'b0000) begin miscompares++; $display("FAIL reset_alu_ctrl: got %b want 0000", alu_ctrl); end
    vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", {req0_ready, req1_ready}); end
    vectors++; if ({rsp0_result, rsp0_zero, rsp0_err} !== {{WIDTH{1'b0}}, 2'b00}) begin miscompares++; $display("FAIL reset_rsp_regs: got %h/%b/%b want 0/0/0", rsp0_result, rsp0_zero, rsp0_err); end
    step();
    Reset_L = 1'b1;
    step();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd3; req0_ctrl = OP_ADD;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0;
    vectors++; if ({alu_a, alu_b, alu_ctrl} !== {64'd5, 64'd3, OP_ADD}) begin miscompares++; $display("FAIL add_alu_bus: got %h %h %b want 5 3 0010", alu_a, alu_b, alu_ctrl); end
    vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL add_valid_early: got %b want 0", rsp0_valid); end
    step();
    vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin miscompares++; $display("FAIL add_rsp_valid: got %b want 10", {rsp0_valid, rsp1_valid}); end
    vectors++; if ({rsp0_result, rsp0_zero, rsp0_err} !== {64'd8, 2'b00}) begin miscompares++; $display("FAIL add_result: got %h/%b/%b want 8/0/0", rsp0_result, rsp0_zero, rsp0_err); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL add_release: got %b want 0", rsp0_valid); end
  endtask

  // prio is 1 here: req1 wins the contention, req0 is held off until IDLE.
  task automatic test_stall();
    req1_valid = 1'b1; req1_a = 64'd7; req1_b = 64'd7; req1_ctrl = OP_SUB;
    req0_valid = 1'b1; req0_a = 64'h30; req0_b = 64'h0C; req0_ctrl = OP_OR;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL stall_grant: got %b want 01", {req0_ready, req1_ready}); end
    step();
    req1_valid = 1'b0;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL stall_exec_ready: got %b want 0", req0_ready); end
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({rsp1_valid, rsp0_valid, req0_ready} !== 3'b100) begin miscompares++; $display("FAIL stall_hold_ctl[%0d]: got %b want 100", i, {rsp1_valid, rsp0_valid, req0_ready}); end
      vectors++; if ({rsp1_result, rsp1_zero, rsp1_err} !== {{WIDTH{1'b0}}, 2'b10}) begin miscompares++; $display("FAIL stall_hold_data[%0d]: got %h/%b/%b want 0/1/0", i, rsp1_result, rsp1_zero, rsp1_err); end
      if (i < 3) step();
    end
    rsp1_ready = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hs_ready: got %b want 0", req0_ready); end
    step();
    rsp1_ready = 1'b0;
    vectors++; if ({rsp1_valid, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL stall_next_accept: got %b want 01", {rsp1_valid, req0_ready}); end
    step();
    req0_valid = 1'b0;
    step();
    vectors++; if ({rsp0_valid, rsp0_result} !== {1'b1, 64'h3C}) begin miscompares++; $display("FAIL stall_queued_op: got %b/%h want 1/3c", rsp0_valid, rsp0_result); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_wrap();
    req1_valid = 1'b1; req1_a = {WIDTH{1'b1}}; req1_b = 64'd1; req1_ctrl = OP_ADD;
    step();
    req1_valid = 1'b0;
    step();
    vectors++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, {WIDTH{1'b0}}, 2'b10}) begin miscompares++; $display("FAIL wrap_add: got %b/%h/%b/%b want 1/0/1/0", rsp1_valid, rsp1_result, rsp1_zero, rsp1_err); end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
  endtask

  // Continuous contention, PassB of own ID, responses always accepted.
  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_a = '0; req0_b = 64'd0; req0_ctrl = OP_PASSB;
    req1_valid = 1'b1; req1_a = '0; req1_b = 64'd1; req1_ctrl = OP_PASSB;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      automatic int  ph = k % 3;
      automatic logic g = logic'((k / 3) % 2);
      automatic logic [1:0] exp_rdy = (ph == 0) ? (g ? 2'b01 : 2'b10) : 2'b00;
      automatic logic [1:0] exp_vld = (ph == 2) ? (g ? 2'b01 : 2'b10) : 2'b00;
      vectors++; if ({req0_ready, req1_ready} !== exp_rdy) begin miscompares++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, {req0_ready, req1_ready}, exp_rdy); end
      vectors++; if ({rsp0_valid, rsp1_valid} !== exp_vld) begin miscompares++; $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", k, {rsp0_valid, rsp1_valid}, exp_vld); end
      if (ph == 2) begin
        vectors++; if (rsp0_result !== WIDTH'(g)) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", k, rsp0_result, WIDTH'(g)); end
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  // The last legal op was req1's PassB with a=0, b=1.
  task automatic test_illegal();
    req0_valid = 1'b1; req0_a = 64'h1234; req0_b = 64'h5678; req0_ctrl = 4'b1111;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready: got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    vectors++; if ({alu_a, alu_b, alu_ctrl} !== {64'd0, 64'd1, OP_PASSB}) begin miscompares++; $display("FAIL illegal_alu_bus: got %h %h %b want 0 1 0111", alu_a, alu_b, alu_ctrl); end
    step();
    vectors++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, {WIDTH{1'b0}}, 2'b11}) begin miscompares++; $display("FAIL illegal_rsp: got %b/%h/%b/%b want 1/0/1/1", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
  endtask

  // prio is 1 on entry; reset must bring it back to 0.
  task automatic test_reset_exec();
    req0_valid = 1'b1; req0_a = 64'hFF; req0_b = 64'h0F; req0_ctrl = OP_AND;
    step();
    req0_valid = 1'b0;
    vectors++; if (alu_a !== 64'hFF) begin miscompares++; $display("FAIL rst_exec_loaded: got %h want ff", alu_a); end
    #1;
    Reset_L = 1'b0;
    #1;
    vectors++; if ({alu_a, alu_ctrl, rsp0_valid} !== {{WIDTH{1'b0}}, 4'b0000, 1'b0}) begin miscompares++; $display("FAIL rst_exec_async: got %h/%b/%b want 0/0000/0", alu_a, alu_ctrl, rsp0_valid); end
    step();
    Reset_L = 1'b1;
    step();
    vectors++; if ({rsp0_valid, rsp1_valid, rsp0_err} !== 3'b000) begin miscompares++; $display("FAIL rst_exec_dropped: got %b want 000", {rsp0_valid, rsp1_valid, rsp0_err}); end
    step();
    vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_exec_no_rsp: got %b want 00", {rsp0_valid, rsp1_valid}); end
    req0_valid = 1'b1;
    req1_valid = 1'b1; req1_a = 64'h1; req1_b = 64'h2; req1_ctrl = OP_OR;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rst_exec_prio: got %b want 10", {req0_ready, req1_ready}); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    vectors++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 64'h0F, 2'b00}) begin miscompares++; $display("FAIL rst_exec_next_op: got %b/%h/%b/%b want 1/f/0/0", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err); end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_illegal();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
